// File: rtl/flag_branch_unit.sv
// flag_branch_unit: masked ALU flag register, forwarded branch resolve, flush pulse and branch stats.
module flag_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             ex_stall,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             br_taken,
  output logic             br_flush,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken_cnt
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nx;
  logic wz, wnv, ez, en, ev, cond_ok, resolve;
  logic [7:0] cond_tbl;
  always_comb begin
    wz = ex_valid & ~ex_stall & ~ex_opcode[3] & (ex_opcode[1:0] != 2'b11);
    wnv = ex_valid & ~ex_stall & (ex_opcode[3:1] == 3'b000);
    ez = wz ? alu_z : flag_z;
    en = wnv ? alu_n : flag_n;
    ev = wnv ? alu_v : flag_v;
    // indexed by br_cond: UNCOND, OVFL, LTE, GTE, LT, GT, EQ, NEQ
    cond_tbl = {1'b1, ev, en | ez, ez | ~en, en, ~ez & ~en, ez, ~ez};
    cond_ok = cond_tbl[br_cond];
    br_taken = br_valid & (state == IDLE) & cond_ok;
    resolve = br_valid & ~ex_stall & (state == IDLE);
    state_nx = (state == IDLE && resolve && cond_ok) ? FLUSH : IDLE;
  end
  assign br_flush = (state == FLUSH);
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      state <= IDLE;
      br_total <= '0;
      br_taken_cnt <= '0;
    end else begin
      if (wz) flag_z <= alu_z;
      if (wnv) flag_n <= alu_n;
      if (wnv) flag_v <= alu_v;
      state <= state_nx;
      if (resolve && !(&br_total)) br_total <= br_total + 1'b1;
      if (resolve && cond_ok && !(&br_taken_cnt)) br_taken_cnt <= br_taken_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed plan steps plus random traffic against a behavioural model.
module tb_flag_branch_unit;
  localparam int CNT_W = 10;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 0, rst, ex_valid, ex_stall, br_valid, alu_z, alu_n, alu_v;
  logic [3:0] ex_opcode;
  logic [2:0] br_cond;
  logic flag_z, flag_n, flag_v, br_taken, br_flush;
  logic [CNT_W-1:0] br_total, br_taken_cnt;
  int checks = 0, errors = 0;
  logic mz, mn, mv, mflush;
  int mtot, mtk;
  always #5 clk = ~clk;
  flag_branch_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .ex_stall(ex_stall),
    .br_valid(br_valid), .br_cond(br_cond), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .br_taken(br_taken), .br_flush(br_flush),
    .br_total(br_total), .br_taken_cnt(br_taken_cnt)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic bit cond_true(input int c, input bit z, input bit n, input bit v);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1;
    endcase
  endfunction
  task automatic step(input bit r, input bit ev, input int op, input bit z, input bit n,
                      input bit v, input bit st, input bit bv, input int c);
    bit wz, wnv, fz, fn, fv, tk, res;
    rst = r; ex_valid = ev; ex_opcode = op[3:0]; alu_z = z; alu_n = n; alu_v = v;
    ex_stall = st; br_valid = bv; br_cond = c[2:0];
    wz = ev && !st && (op inside {0, 1, 2, 4, 5, 6});
    wnv = ev && !st && (op inside {0, 1});
    fz = wz ? z : mz;
    fn = wnv ? n : mn;
    fv = wnv ? v : mv;
    tk = bv && !mflush && cond_true(c, fz, fn, fv);
    res = bv && !st && !mflush;
    #1;
    chk("br_taken", br_taken, tk);
    @(posedge clk);
    if (r) begin
      mz = 0; mn = 0; mv = 0; mflush = 0; mtot = 0; mtk = 0;
    end else begin
      mz = fz; mn = fn; mv = fv;
      mflush = res && tk;
      if (res && mtot < MAXC) mtot++;
      if (res && tk && mtk < MAXC) mtk++;
    end
    #1;
    chk("flag_z", flag_z, mz);
    chk("flag_n", flag_n, mn);
    chk("flag_v", flag_v, mv);
    chk("br_flush", br_flush, mflush);
    chk("br_total", br_total, mtot);
    chk("br_taken_cnt", br_taken_cnt, mtk);
  endtask
  initial begin
    mz = 0; mn = 0; mv = 0; mflush = 0; mtot = 0; mtk = 0;
    #2;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_flags", {flag_z, flag_n, flag_v, br_flush}, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0, 0);
    chk("add_flags", {flag_z, flag_n, flag_v}, 3'b011);
    step(0, 1, 2, 1, 0, 0, 0, 0, 0);
    chk("xor_flags", {flag_z, flag_n, flag_v}, 3'b111);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 1, 1);
    chk("fwd_flush", br_flush, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_flush_end", br_flush, 0);
    chk("fwd_counts", {br_total, br_taken_cnt}, {10'd1, 10'd1});
    step(0, 1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 1, 1, 7);
    chk("stall_no_flush", br_flush, 0);
    step(0, 1, 0, 1, 0, 1, 0, 1, 7);
    chk("unstall_flush", br_flush, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    chk("flush_slot_total", br_total, 4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    step(1, 0, 0, 0, 0, 0, 0, 1, 7);
    chk("rst_in_flush", {br_flush, br_total}, 0);
    for (int i = 0; i < MAXC; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 7);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    chk("sat_total", br_total, MAXC);
    chk("sat_taken", br_taken_cnt, MAXC);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 6);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 40) == 0, 1'($urandom), int'($urandom_range(0, 15)),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
           1'($urandom), int'($urandom_range(0, 7)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Consumer side of the EX-stage ALU flag interface. Latches the ALU's Z/N/V outputs into the architectural flag register using per-opcode write masks. Resolves conditional branches in ID against those flags, forwarding same-cycle EX flags. Generates a one-cycle fetch-flush pulse and keeps saturating branch statistics.

## Interface
Parameters:
- CNT_W, 16, width of the branch statistics counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_opcode  in  4  opcode of the EX instruction
- alu_z  in  1  ALU zero flag for the EX instruction
- alu_n  in  1  ALU negative flag for the EX instruction
- alu_v  in  1  ALU overflow flag for the EX instruction
- ex_stall  in  1  pipeline stall: freezes flags, FSM entry and counters
- br_valid  in  1  ID stage holds a conditional branch (B/BR)
- br_cond  in  3  branch condition code
- flag_z  out  1  architectural Z
- flag_n  out  1  architectural N
- flag_v  out  1  architectural V
- br_taken  out  1  combinational branch decision for the ID instruction
- br_flush  out  1  registered flush pulse to IF/ID
- br_total  out  CNT_W  branches resolved
- br_taken_cnt  out  CNT_W  branches taken

## Operation
- Write masks (Z,N,V), applied when ex_valid=1 and ex_stall=0:
  - 0000 ADD and 0001 SUB write Z, N, V.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR write Z only.
  - 0011 RED, 0111 PADDSB and all 1xxx opcodes write nothing.
  - Flags outside the mask hold their value.
- Effective flags: per bit, the ALU flag when that bit's mask is active this cycle, else the register value. Forwarding is masked per bit.
- Conditions, evaluated on the effective flags:
  - 000 NEQ: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or (Z=0 and N=0)
  - 101 LTE: N=1 or Z=1
  - 110 OVFL: V=1
  - 111 UNCOND: 1
- FSM states: IDLE and FLUSH.
  - A branch resolves when br_valid=1, ex_stall=0 and the state is IDLE.
  - br_taken = br_valid AND state==IDLE AND condition true. ex_stall does not mask br_taken; consumers qualify it with the stall.
  - IDLE -> FLUSH when a resolved branch is taken.
  - FLUSH -> IDLE unconditionally after one cycle, even if ex_stall=1.
  - In FLUSH, br_taken is forced to 0 because the ID slot is being squashed.
  - br_flush = (state==FLUSH).
- Counters:
  - br_total increments on every resolved branch.
  - br_taken_cnt increments on every resolved taken branch.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset values: flag_z=0, flag_n=0, flag_v=0, state=IDLE, br_flush=0, br_total=0, br_taken_cnt=0.
- Flag latency: ALU flags are visible on flag_* one cycle after the EX cycle. They are visible on br_taken in the same cycle through forwarding.
- Flush latency: br_flush is high exactly one cycle after the cycle in which br_taken is resolved high. Back-to-back flushes are impossible.
- Simultaneous flag write and branch: the branch uses the forwarded, post-write flags.
- Stall:
  - Flag register, counters and the IDLE->FLUSH transition are frozen.
  - br_taken is still driven combinationally.
- Reset takes priority over every other event, including mid-FLUSH. With rst=1 in a FLUSH cycle, br_flush is 0 in the following cycle.
- Counters at saturation: at 0xFFFF (CNT_W=16), a further resolved branch leaves the value at 0xFFFF.

## Test plan
- Reset, then ADD with alu_z/n/v=0/1/1. Next cycle: flag_n=1, flag_v=1, flag_z=0. Then an XOR with alu_z=1, alu_n=0: flag_z=1, N and V keep 1/1.
- Forwarding: registers Z=0. SUB in EX with alu_z=1, plus br_valid=1 with cond=001 in the same cycle -> br_taken=1 that cycle. br_flush=1 next cycle, then 0. br_total=1, br_taken_cnt=1.
- Masked forwarding: registers N=1. RED in EX with alu_n=0, branch cond=011 -> br_taken=1, because RED does not write N.
- Stall: ex_stall=1 with ADD valid and a taken cond=111 branch. Flags unchanged, no flush, counters unchanged. Drop the stall the next cycle -> update, flush and counts all occur.
- FLUSH slot: a taken branch, then br_valid=1 with cond=111 in the FLUSH cycle -> br_taken=0 and br_total is not incremented. rst=1 during FLUSH -> all outputs return to reset values the next cycle.
- Saturation: preload by driving 65535 taken cond=111 branches, then one more -> br_total=br_taken_cnt=0xFFFF. cond=110 with V=0 -> br_taken=0.
